// File: rtl/guess_score_engine.sv
// guess_score_engine
//   Bulls-and-Cows scoring core. A free-running 16-bit LFSR supplies
//   candidate digits to build a secret of DIGITS distinct decimal digits.
//   Keypad codes then edit a guess, and each submitted guess is scored one
//   digit per cycle as A (right digit, right place) and B (right digit,
//   wrong place). The core also counts attempts and applies an optional
//   try limit.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   key_vld        one-cycle strobe qualifying key_code
//   key_code       0-9 digit, A submit, B clear guess, C new game,
//                  F toggle reveal; D/E ignored
//   guess_digits   entered digits, least significant digit in [3:0]
//   secret_digits  secret digits while reveal=1, otherwise zero
//   a_cnt, b_cnt   score of the last scored guess
//   tries          scored guesses this game, saturating
//   score_vld      one-cycle pulse when a_cnt/b_cnt/tries update
//   err            one-cycle pulse when a submit is rejected
//   ready          high while waiting for keys
//   win, lose      high in the terminal states
//   reveal         secret display enable
//
// Build option
//   GUESS_DUP_REJECT_EN : when defined, a guess that repeats a digit is
//   rejected on submit (err pulse, guess kept for editing, no try used).
module guess_score_engine #(
  parameter int          DIGITS    = 4,
  parameter int          ATT_W     = 8,
  parameter int          MAX_TRIES = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_vld,
  input  logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          guess_digits,
  output logic [4*DIGITS-1:0]          secret_digits,
  output logic [$clog2(DIGITS+1)-1:0]  a_cnt,
  output logic [$clog2(DIGITS+1)-1:0]  b_cnt,
  output logic [ATT_W-1:0]             tries,
  output logic                         score_vld,
  output logic                         err,
  output logic                         ready,
  output logic                         win,
  output logic                         lose,
  output logic                         reveal
);

  localparam int                CW   = $clog2(DIGITS+1);
  localparam int                GW   = 4*DIGITS;
  localparam logic [CW-1:0]     DN   = CW'(DIGITS);
  localparam logic [ATT_W-1:0]  MAXT = ATT_W'(MAX_TRIES);

  typedef enum logic [2:0] {S_GEN, S_ENTRY, S_CMP, S_SCORE, S_WIN, S_LOSE} state_t;

  state_t            r_state, w_nxt;
  logic [15:0]       r_lfsr;
  logic [GW-1:0]     r_sec, r_guess;
  logic [CW-1:0]     r_nsec, r_nent, r_i;
  logic [CW-1:0]     r_acc_a, r_acc_b, r_a, r_b;
  logic [ATT_W-1:0]  r_tries;
  logic              r_score_vld, r_err, r_ready, r_win, r_lose, r_reveal;

  logic [3:0]        w_cand, w_gi, w_si;
  logic              w_cand_dup, w_accept;
  logic              w_k_dig, w_k_sub, w_k_clr, w_k_new, w_k_rev;
  logic              w_gdup, w_sub_ok, w_newgame;
  logic              w_hit_a, w_in_sec, w_last;
  logic [CW-1:0]     w_a_nxt, w_b_nxt;
  logic [ATT_W-1:0]  w_tries_inc;

  // ---------------- secret generation ----------------
  assign w_cand = r_lfsr[3:0];

  // Candidate must differ from the digits already stored (positions < r_nsec).
  always_comb begin
    w_cand_dup = 1'b0;
    for (int j = 0; j < DIGITS; j++)
      if (CW'(j) < r_nsec && r_sec[4*j +: 4] == w_cand) w_cand_dup = 1'b1;
  end

  assign w_accept = (w_cand < 4'd10) && !w_cand_dup;

  // ---------------- key decode ----------------
  assign w_k_dig = key_vld && (key_code < 4'd10);
  assign w_k_sub = key_vld && (key_code == 4'hA);
  assign w_k_clr = key_vld && (key_code == 4'hB);
  assign w_k_new = key_vld && (key_code == 4'hC);
  assign w_k_rev = key_vld && (key_code == 4'hF);

`ifdef GUESS_DUP_REJECT_EN
  always_comb begin
    w_gdup = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      for (int j = i + 1; j < DIGITS; j++)
        if (r_guess[4*i +: 4] == r_guess[4*j +: 4]) w_gdup = 1'b1;
  end
`else
  assign w_gdup = 1'b0;
`endif

  assign w_sub_ok  = w_k_sub && (r_nent == DN) && !w_gdup;
  assign w_newgame = w_k_new &&
                     (r_state == S_ENTRY || r_state == S_WIN || r_state == S_LOSE);

  // ---------------- sequential compare ----------------
  assign w_gi    = r_guess[4*r_i +: 4];
  assign w_si    = r_sec[4*r_i +: 4];
  assign w_hit_a = (w_gi == w_si);
  assign w_last  = (r_i == CW'(DIGITS-1));

  always_comb begin
    w_in_sec = 1'b0;
    for (int j = 0; j < DIGITS; j++)
      if (r_sec[4*j +: 4] == w_gi) w_in_sec = 1'b1;
  end

  assign w_a_nxt     = r_acc_a + {{(CW-1){1'b0}}, w_hit_a};
  assign w_b_nxt     = r_acc_b + {{(CW-1){1'b0}}, (!w_hit_a && w_in_sec)};
  assign w_tries_inc = (&r_tries) ? r_tries : r_tries + ATT_W'(1);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_GEN;
    else        r_state <= w_nxt;
  end

  // r_a / r_tries already hold this guess's result while in S_SCORE.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_GEN:   if (w_accept && r_nsec == CW'(DIGITS-1)) w_nxt = S_ENTRY;
      S_ENTRY: if (w_newgame)     w_nxt = S_GEN;
               else if (w_sub_ok) w_nxt = S_CMP;
      S_CMP:   if (w_last) w_nxt = S_SCORE;
      S_SCORE: if (r_a == DN)                              w_nxt = S_WIN;
               else if (MAX_TRIES != 0 && r_tries >= MAXT) w_nxt = S_LOSE;
               else                                        w_nxt = S_ENTRY;
      S_WIN,
      S_LOSE:  if (w_newgame) w_nxt = S_GEN;
      default: w_nxt = S_GEN;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= LFSR_SEED;
      r_sec       <= '0;
      r_guess     <= '0;
      r_nsec      <= '0;
      r_nent      <= '0;
      r_i         <= '0;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tries     <= '0;
      r_score_vld <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_reveal    <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_score_vld <= 1'b0;
      r_err       <= 1'b0;
      // status flags track the state register edge for edge
      r_ready     <= (w_nxt == S_ENTRY);
      r_win       <= (w_nxt == S_WIN);
      r_lose      <= (w_nxt == S_LOSE);

      if (w_newgame) begin
        r_guess  <= '0;
        r_nent   <= '0;
        r_sec    <= '0;
        r_nsec   <= '0;
        r_tries  <= '0;
        r_a      <= '0;
        r_b      <= '0;
        r_reveal <= 1'b0;
      end else begin
        case (r_state)
          S_GEN: if (w_accept) begin
            r_sec[4*r_nsec +: 4] <= w_cand;
            r_nsec               <= r_nsec + CW'(1);
          end
          S_ENTRY: begin
            if (w_k_dig) begin
              r_guess <= {r_guess[GW-5:0], key_code};
              if (r_nent != DN) r_nent <= r_nent + CW'(1);
            end else if (w_k_clr) begin
              r_guess <= '0;
              r_nent  <= '0;
            end else if (w_k_rev) begin
              r_reveal <= ~r_reveal;
            end else if (w_k_sub) begin
              if (w_sub_ok) begin
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_i     <= '0;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_CMP: begin
            r_acc_a <= w_a_nxt;
            r_acc_b <= w_b_nxt;
            r_i     <= r_i + CW'(1);
            // Result is latched on the way into S_SCORE so it is visible
            // during the scoring cycle itself.
            if (w_last) begin
              r_a         <= w_a_nxt;
              r_b         <= w_b_nxt;
              r_tries     <= w_tries_inc;
              r_score_vld <= 1'b1;
            end
          end
          S_SCORE: begin
            if (w_nxt == S_LOSE) r_reveal <= 1'b1;
            else if (w_nxt == S_ENTRY) begin
              r_guess <= '0;
              r_nent  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_digits  = r_guess;
  assign secret_digits = r_sec & {GW{r_reveal}};
  assign a_cnt         = r_a;
  assign b_cnt         = r_b;
  assign tries         = r_tries;
  assign score_vld     = r_score_vld;
  assign err           = r_err;
  assign ready         = r_ready;
  assign win           = r_win;
  assign lose          = r_lose;
  assign reveal        = r_reveal;

endmodule
